alu_ctrl_issue: RTL and testbench
=================================

ALU_CTRL_ISSUE -- requirements
Module: alu_ctrl_issue

Interface
REQ-001 The block SHALL have no parameters; all widths are fixed.
REQ-002 clk  input  1  single clock; all state updates on its rising edge.
REQ-003 reset  input  1  asynchronous, active-high reset.
REQ-004 id_valid  input  1  ID stage holds a real instruction.
REQ-005 id_instr  input  32  MIPS instruction word from ID.
REQ-006 stall  input  1  hold ID/EX contents this cycle.
REQ-007 flush  input  1  replace ID/EX contents with a bubble.
REQ-008 ex_valid  output  1  registered; EX holds a real instruction.
REQ-009 ex_alu_ctrl  output  4  registered ALU command.
REQ-010 ex_alu_src  output  1  registered; 1 = operand 2 is ex_imm, 0 = register.
REQ-011 ex_imm  output  32  registered extended immediate.
REQ-012 ex_is_branch  output  1  registered; instruction resolves via the ALU zero output.
REQ-013 ex_illegal  output  1  registered; instruction not decodable.
REQ-014 illegal_count  output  8  saturating count of illegal instructions issued.

Function
REQ-015 Decode SHALL use op = id_instr[31:26], rt = id_instr[20:16], funct = id_instr[5:0], imm = id_instr[15:0].
REQ-016 ALU codes SHALL be: ADD 0000, SUB 0001, AND 0010, NOR 0011, OR 0100, SLT 0101, BEQ 0110, BNE 0111, BGEZ 1111.
REQ-017 For op 000000, funct 100000/100010/100100/100101/100111/101010 SHALL map to ADD/SUB/AND/OR/NOR/SLT, with alu_src 0.
REQ-018 addi 001000 -> ADD and slti 001010 -> SLT SHALL use a sign-extended imm; andi 001100 -> AND and ori 001101 -> OR SHALL use a zero-extended imm; all four SHALL set alu_src 1.
REQ-019 lw 100011 and sw 101011 SHALL map to ADD, alu_src 1, sign-extended imm.
REQ-020 beq 000100 -> BEQ and bne 000101 -> BNE SHALL set alu_src 0 and is_branch 1.
REQ-021 op 000001 with rt 00001 SHALL map to BGEZ, alu_src 0, is_branch 1.
REQ-022 For branches, ex_imm SHALL be the sign-extended imm shifted left by 2.
REQ-023 Any other op/funct/rt combination SHALL be illegal: alu_ctrl 0000, alu_src 0, imm 0, is_branch 0, illegal 1.
REQ-024 Latency SHALL be exactly one cycle from id_instr to the ex_* outputs.
REQ-025 Each cycle the ID/EX register SHALL update according to the first matching rule: flush -> bubble; stall -> hold; otherwise load the decode of id_instr with ex_valid = id_valid.
REQ-026 A bubble SHALL be all ex_* outputs equal to 0, including ex_valid.
REQ-027 flush SHALL win over stall when both are asserted.
REQ-028 When id_valid is 0 on a load cycle, ex_valid SHALL be 0 and the other ex_* fields SHALL be 0.
REQ-029 illegal_count SHALL increment by 1 only on a load cycle with id_valid 1 and an illegal decode.
REQ-030 illegal_count SHALL hold its value on stall, flush, and bubble cycles.
REQ-031 illegal_count SHALL saturate at 255 and never wrap.

Reset
REQ-032 While reset is 1, all ex_* outputs and illegal_count SHALL be 0 immediately, without waiting for a clock edge.
REQ-033 Reset asserted mid-stall SHALL discard the held instruction; after release, the first load edge SHALL behave normally.

Verification
REQ-034 add $1,$2,$3 (0x00430820), id_valid 1 -> next cycle: ex_valid 1, alu_ctrl 0000, alu_src 0, illegal 0.
REQ-035 ori imm 0x8001 -> ex_imm 0x00008001; addi imm 0x8001 -> ex_imm 0xFFFF8001; both with alu_src 1.
REQ-036 bgez with imm 0xFFFF -> alu_ctrl 1111, is_branch 1, ex_imm 0xFFFFFFFC; same op with rt 00000 -> illegal 1.
REQ-037 Load sub (alu_ctrl 0001), then stall for 3 cycles while id_instr changes -> outputs hold 0001; assert stall and flush together -> ex_valid 0 and all fields 0.
REQ-038 Issue 260 illegal words (0xFC000000) with id_valid 1 -> illegal_count = 255; count unchanged on the cycles where id_valid is 0.
REQ-039 Assert reset asynchronously between clock edges while ex_valid is 1 -> all outputs 0 before the next edge.

Source files
------------

// File: rtl/alu_ctrl_issue.sv
// alu_ctrl_issue: decodes a MIPS instruction word in ID into an ALU command
// and registers it into the ID/EX pipeline register.
//
// Ports
//   clk            rising-edge clock
//   reset          asynchronous, active-high reset
//   id_valid       ID stage holds a real instruction
//   id_instr[31:0] instruction word from ID
//   stall          hold ID/EX contents this cycle
//   flush          replace ID/EX contents with a bubble (wins over stall)
//   ex_valid       EX holds a real instruction
//   ex_alu_ctrl    ALU command (4 bits)
//   ex_alu_src     1 = operand 2 is ex_imm, 0 = register
//   ex_imm[31:0]   extended immediate (branch offsets pre-shifted by 2)
//   ex_is_branch   instruction resolves via the ALU zero output
//   ex_illegal     instruction not decodable
//   illegal_count  saturating count of illegal instructions issued
module alu_ctrl_issue (
  input  logic        clk,
  input  logic        reset,
  input  logic        id_valid,
  input  logic [31:0] id_instr,
  input  logic        stall,
  input  logic        flush,
  output logic        ex_valid,
  output logic [3:0]  ex_alu_ctrl,
  output logic        ex_alu_src,
  output logic [31:0] ex_imm,
  output logic        ex_is_branch,
  output logic        ex_illegal,
  output logic [7:0]  illegal_count
);

  typedef enum logic [3:0] {
    ALU_ADD  = 4'b0000,
    ALU_SUB  = 4'b0001,
    ALU_AND  = 4'b0010,
    ALU_NOR  = 4'b0011,
    ALU_OR   = 4'b0100,
    ALU_SLT  = 4'b0101,
    ALU_BEQ  = 4'b0110,
    ALU_BNE  = 4'b0111,
    ALU_BGEZ = 4'b1111
  } alu_op_e;

  logic [5:0]  op;
  logic [4:0]  rt;
  logic [5:0]  funct;
  logic [15:0] imm;
  logic [31:0] imm_sx;
  logic [31:0] imm_zx;
  logic [31:0] imm_br;

  assign op     = id_instr[31:26];
  assign rt     = id_instr[20:16];
  assign funct  = id_instr[5:0];
  assign imm    = id_instr[15:0];
  assign imm_sx = {{16{imm[15]}}, imm};
  assign imm_zx = {16'h0000, imm};
  assign imm_br = {imm_sx[29:0], 2'b00};

  alu_op_e     dec_ctrl;
  logic        dec_src;
  logic [31:0] dec_imm;
  logic        dec_branch;
  logic        dec_illegal;

  // Start from the illegal encoding; each recognised form clears dec_illegal.
  always_comb begin
    dec_ctrl    = ALU_ADD;
    dec_src     = 1'b0;
    dec_imm     = '0;
    dec_branch  = 1'b0;
    dec_illegal = 1'b1;
    unique case (op)
      6'b000000: begin
        dec_illegal = 1'b0;
        case (funct)
          6'b100000: dec_ctrl = ALU_ADD;
          6'b100010: dec_ctrl = ALU_SUB;
          6'b100100: dec_ctrl = ALU_AND;
          6'b100101: dec_ctrl = ALU_OR;
          6'b100111: dec_ctrl = ALU_NOR;
          6'b101010: dec_ctrl = ALU_SLT;
          default:   dec_illegal = 1'b1;
        endcase
      end
      6'b001000: begin dec_ctrl = ALU_ADD; dec_src = 1'b1; dec_imm = imm_sx; dec_illegal = 1'b0; end
      6'b001010: begin dec_ctrl = ALU_SLT; dec_src = 1'b1; dec_imm = imm_sx; dec_illegal = 1'b0; end
      6'b001100: begin dec_ctrl = ALU_AND; dec_src = 1'b1; dec_imm = imm_zx; dec_illegal = 1'b0; end
      6'b001101: begin dec_ctrl = ALU_OR;  dec_src = 1'b1; dec_imm = imm_zx; dec_illegal = 1'b0; end
      6'b100011,
      6'b101011: begin dec_ctrl = ALU_ADD; dec_src = 1'b1; dec_imm = imm_sx; dec_illegal = 1'b0; end
      6'b000100: begin dec_ctrl = ALU_BEQ; dec_branch = 1'b1; dec_imm = imm_br; dec_illegal = 1'b0; end
      6'b000101: begin dec_ctrl = ALU_BNE; dec_branch = 1'b1; dec_imm = imm_br; dec_illegal = 1'b0; end
      6'b000001: begin
        if (rt == 5'b00001) begin
          dec_ctrl    = ALU_BGEZ;
          dec_branch  = 1'b1;
          dec_imm     = imm_br;
          dec_illegal = 1'b0;
        end
      end
      default: ;
    endcase
    // Illegal words carry no command fields, only the illegal flag.
    if (dec_illegal) begin
      dec_ctrl   = ALU_ADD;
      dec_src    = 1'b0;
      dec_imm    = '0;
      dec_branch = 1'b0;
    end
  end

  logic load;
  assign load = !flush && !stall;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ex_valid     <= 1'b0;
      ex_alu_ctrl  <= '0;
      ex_alu_src   <= 1'b0;
      ex_imm       <= '0;
      ex_is_branch <= 1'b0;
      ex_illegal   <= 1'b0;
    end else if (flush || (load && !id_valid)) begin
      ex_valid     <= 1'b0;
      ex_alu_ctrl  <= '0;
      ex_alu_src   <= 1'b0;
      ex_imm       <= '0;
      ex_is_branch <= 1'b0;
      ex_illegal   <= 1'b0;
    end else if (load) begin
      ex_valid     <= 1'b1;
      ex_alu_ctrl  <= dec_ctrl;
      ex_alu_src   <= dec_src;
      ex_imm       <= dec_imm;
      ex_is_branch <= dec_branch;
      ex_illegal   <= dec_illegal;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      illegal_count <= '0;
    end else if (load && id_valid && dec_illegal && (illegal_count != 8'hFF)) begin
      illegal_count <= illegal_count + 8'd1;
    end
  end

endmodule

// File: tb/tb_alu_ctrl_issue.sv
module tb_alu_ctrl_issue;

  logic        clk;
  logic        reset;
  logic        id_valid;
  logic [31:0] id_instr;
  logic        stall;
  logic        flush;
  logic        ex_valid;
  logic [3:0]  ex_alu_ctrl;
  logic        ex_alu_src;
  logic [31:0] ex_imm;
  logic        ex_is_branch;
  logic        ex_illegal;
  logic [7:0]  illegal_count;

  alu_ctrl_issue dut (
    .clk          (clk),
    .reset        (reset),
    .id_valid     (id_valid),
    .id_instr     (id_instr),
    .stall        (stall),
    .flush        (flush),
    .ex_valid     (ex_valid),
    .ex_alu_ctrl  (ex_alu_ctrl),
    .ex_alu_src   (ex_alu_src),
    .ex_imm       (ex_imm),
    .ex_is_branch (ex_is_branch),
    .ex_illegal   (ex_illegal),
    .illegal_count(illegal_count)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    logic        valid;
    logic [3:0]  ctrl;
    logic        src;
    logic [31:0] imm;
    logic        br;
    logic        ill;
    logic [7:0]  cnt;
  } exp_t;

  exp_t sb_q[$];
  exp_t m;
  int   checks   = 0;
  int   failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, req, $time);
    end
  endtask

  function automatic exp_t zero_ex(input logic [7:0] cnt);
    exp_t e;
    e.valid = 1'b0; e.ctrl = 4'h0; e.src = 1'b0; e.imm = 32'h0;
    e.br = 1'b0; e.ill = 1'b0; e.cnt = cnt;
    return e;
  endfunction

  // Reference decode straight from the instruction-set table.
  function automatic exp_t ref_decode(input logic [31:0] w, input logic [7:0] cnt);
    exp_t e;
    logic [5:0]  op;
    logic [31:0] sx, zx;
    op = w[31:26];
    sx = 32'($signed(w[15:0]));
    zx = 32'(w[15:0]);
    e = zero_ex(cnt);
    e.valid = 1'b1;
    e.ill   = 1'b0;
    if (op == 6'h00 && w[5:0] == 6'h20)      e.ctrl = 4'd0;
    else if (op == 6'h00 && w[5:0] == 6'h22) e.ctrl = 4'd1;
    else if (op == 6'h00 && w[5:0] == 6'h24) e.ctrl = 4'd2;
    else if (op == 6'h00 && w[5:0] == 6'h25) e.ctrl = 4'd4;
    else if (op == 6'h00 && w[5:0] == 6'h27) e.ctrl = 4'd3;
    else if (op == 6'h00 && w[5:0] == 6'h2A) e.ctrl = 4'd5;
    else if (op == 6'h08) begin e.ctrl = 4'd0; e.src = 1; e.imm = sx; end
    else if (op == 6'h0A) begin e.ctrl = 4'd5; e.src = 1; e.imm = sx; end
    else if (op == 6'h0C) begin e.ctrl = 4'd2; e.src = 1; e.imm = zx; end
    else if (op == 6'h0D) begin e.ctrl = 4'd4; e.src = 1; e.imm = zx; end
    else if (op == 6'h23 || op == 6'h2B) begin e.ctrl = 4'd0; e.src = 1; e.imm = sx; end
    else if (op == 6'h04) begin e.ctrl = 4'd6;  e.br = 1; e.imm = sx * 4; end
    else if (op == 6'h05) begin e.ctrl = 4'd7;  e.br = 1; e.imm = sx * 4; end
    else if (op == 6'h01 && w[20:16] == 5'd1) begin e.ctrl = 4'd15; e.br = 1; e.imm = sx * 4; end
    else e.ill = 1'b1;
    return e;
  endfunction

  // One pipeline cycle: drive at negedge, predict the state after the next rising edge.
  task automatic cycle(input logic v, input logic [31:0] w, input logic st, input logic fl);
    exp_t d;
    int   c;
    @(negedge clk);
    id_valid = v; id_instr = w; stall = st; flush = fl;
    if (fl) m = zero_ex(m.cnt);
    else if (!st) begin
      if (v) begin
        d = ref_decode(w, m.cnt);
        if (d.ill) begin
          c = int'(m.cnt) + 1;
          d.cnt = (c > 255) ? 8'd255 : 8'(c);
        end
        m = d;
      end else m = zero_ex(m.cnt);
    end
    sb_q.push_back(m);
  endtask

  // Monitor: one registered result per rising edge, compared just after it.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (sb_q.size() > 0) begin
        e = sb_q.pop_front();
        chk("ex_valid",      32'(ex_valid),      32'(e.valid));
        chk("ex_alu_ctrl",   32'(ex_alu_ctrl),   32'(e.ctrl));
        chk("ex_alu_src",    32'(ex_alu_src),    32'(e.src));
        chk("ex_imm",        ex_imm,             e.imm);
        chk("ex_is_branch",  32'(ex_is_branch),  32'(e.br));
        chk("ex_illegal",    32'(ex_illegal),    32'(e.ill));
        chk("illegal_count", 32'(illegal_count), 32'(e.cnt));
      end
    end
  end

  function automatic logic [31:0] rand_instr();
    logic [31:0] w;
    logic [5:0]  rfun [6] = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h27, 6'h2A};
    logic [5:0]  iops [6] = '{6'h08, 6'h0A, 6'h0C, 6'h0D, 6'h23, 6'h2B};
    w = $urandom;
    case ($urandom_range(0, 4))
      0: begin
        w[31:26] = 6'h00;
        if ($urandom_range(0, 3) != 0) w[5:0] = rfun[$urandom_range(0, 5)];
      end
      1: w[31:26] = iops[$urandom_range(0, 5)];
      2: w[31:26] = ($urandom_range(0, 1) == 1) ? 6'h04 : 6'h05;
      3: begin
        w[31:26] = 6'h01;
        if ($urandom_range(0, 2) != 0) w[20:16] = 5'd1;
      end
      default: ;
    endcase
    return w;
  endfunction

  task automatic check_all_zero(input string tag);
    chk({tag, "_valid"}, 32'(ex_valid),      32'h0);
    chk({tag, "_ctrl"},  32'(ex_alu_ctrl),   32'h0);
    chk({tag, "_src"},   32'(ex_alu_src),    32'h0);
    chk({tag, "_imm"},   ex_imm,             32'h0);
    chk({tag, "_br"},    32'(ex_is_branch),  32'h0);
    chk({tag, "_ill"},   32'(ex_illegal),    32'h0);
    chk({tag, "_cnt"},   32'(illegal_count), 32'h0);
  endtask

  initial begin
    reset = 1'b1; id_valid = 1'b0; id_instr = '0; stall = 1'b0; flush = 1'b0;
    m = zero_ex(8'd0);
    repeat (3) @(negedge clk);
    check_all_zero("reset");
    reset = 1'b0;

    // Directed decodes.
    cycle(1, 32'h00430820, 0, 0);   // add
    cycle(1, 32'h34008001, 0, 0);   // ori 0x8001
    cycle(1, 32'h20008001, 0, 0);   // addi 0x8001
    cycle(1, 32'h0401FFFF, 0, 0);   // bgez -1
    cycle(1, 32'h0400FFFF, 0, 0);   // op 1, rt 0: illegal
    cycle(1, 32'h1000FFFE, 0, 0);   // beq
    cycle(0, 32'h00430820, 0, 0);   // not valid: bubble
    // sub held across a 3-cycle stall, then stall+flush.
    cycle(1, 32'h00430822, 0, 0);
    for (int unsigned i = 0; i < 3; i++) cycle(1, rand_instr(), 1, 0);
    cycle(1, 32'h00430820, 1, 1);
    cycle(1, 32'hFC000000, 1, 1);   // flush suppresses counting

    // Randomized traffic.
    for (int unsigned i = 0; i < 400; i++)
      cycle($urandom_range(0, 9) < 8, rand_instr(),
            $urandom_range(0, 9) < 2, $urandom_range(0, 9) == 0);

    // Asynchronous reset mid-stall while a valid instruction is held.
    cycle(1, 32'hFC000000, 0, 0);
    cycle(1, 32'h00430820, 0, 0);
    cycle(1, rand_instr(), 1, 0);
    @(posedge clk);
    #3;
    chk("pre_reset_valid", 32'(ex_valid), 32'h1);
    reset = 1'b1;
    #1;
    check_all_zero("async_reset");
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0; stall = 1'b0; id_valid = 1'b0;
    m = zero_ex(8'd0);
    cycle(1, 32'h00430822, 0, 0);

    // Saturation with interleaved invalid cycles.
    for (int unsigned i = 0; i < 260; i++) begin
      cycle(1, 32'hFC000000, 0, 0);
      if (i % 40 == 0) cycle(0, 32'hFC000000, 0, 0);
    end
    cycle(0, 32'hFC000000, 0, 0);
    @(posedge clk);
    #2;
    chk("count_saturated", 32'(illegal_count), 32'd255);
    chk("scoreboard_drained", 32'(sb_q.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
